mod_phase_sequencer: RTL and testbench

MOD_PHASE_SEQUENCER -- requirements
Module: mod_phase_sequencer

---
 rtl/mod_phase_sequencer.sv | 152 +++++++++++++++
 tb/tb_mod_phase_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_phase_sequencer.sv
// Phase-sweep sequencer for a modulation generator: settles after every
// W_* change, then holds MOD_EN high for the exposure window of each phase.
module mod_phase_sequencer #(
  parameter int SETTLE_CYCLES = 64,
  parameter int EXP_W         = 16
) (
  input  logic             USER_CLOCK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic             ABORT,
  input  logic [2:0]       CFG_FREQ_SEL,
  input  logic [3:0]       CFG_DUTY_SEL,
  input  logic [4:0]       CFG_PHASE_START,
  input  logic [4:0]       CFG_PHASE_STEP,
  input  logic [4:0]       CFG_NUM_PHASES,
  input  logic [EXP_W-1:0] CFG_EXPOSURE,
  output logic [2:0]       W_FREQ_SEL,
  output logic [4:0]       W_PHASE_SEL,
  output logic [3:0]       W_DUTY_SEL,
  output logic             MOD_EN,
  output logic [4:0]       PHASE_IDX,
  output logic             FRAME_STROBE,
  output logic             BUSY,
  output logic             DONE
);

  // One down-counter serves both windows, so it must cover the wider of the two.
  localparam int CNT_W = (EXP_W > 16) ? EXP_W : 16;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_EXPOSE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_step;
  logic [4:0]       r_last_idx;
  logic [EXP_W-1:0] r_exp_load;

  logic [2:0]       r_freq_sel;
  logic [4:0]       r_phase_sel;
  logic [3:0]       r_duty_sel;
  logic             r_mod_en;
  logic [4:0]       r_phase_idx;
  logic             r_frame_strobe;
  logic             r_busy;
  logic             r_done;

  logic [2:0]       w_freq_clamped;
  logic [4:0]       w_last_idx;
  logic [EXP_W-1:0] w_exp_load;

  // Degenerate configuration values are normalised before being latched.
  assign w_freq_clamped = (CFG_FREQ_SEL > 3'd5) ? 3'd5 : CFG_FREQ_SEL;
  assign w_last_idx     = (CFG_NUM_PHASES == 5'd0) ? 5'd0 : CFG_NUM_PHASES - 5'd1;
  assign w_exp_load     = (CFG_EXPOSURE == '0) ? '0 : CFG_EXPOSURE - EXP_W'(1);

  always_ff @(posedge USER_CLOCK) begin
    if (!RESET_N) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_step         <= '0;
      r_last_idx     <= '0;
      r_exp_load     <= '0;
      r_freq_sel     <= '0;
      r_phase_sel    <= '0;
      r_duty_sel     <= '0;
      r_mod_en       <= 1'b0;
      r_phase_idx    <= '0;
      r_frame_strobe <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else if (ABORT) begin
      // W_* and PHASE_IDX deliberately hold so the generator is not disturbed.
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_mod_en       <= 1'b0;
      r_frame_strobe <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_done         <= 1'b0;
      r_frame_strobe <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_step      <= CFG_PHASE_STEP;
            r_last_idx  <= w_last_idx;
            r_exp_load  <= w_exp_load;
            r_freq_sel  <= w_freq_clamped;
            r_duty_sel  <= CFG_DUTY_SEL;
            r_phase_sel <= CFG_PHASE_START;
            r_phase_idx <= '0;
            r_cnt       <= SETTLE_LOAD;
            r_busy      <= 1'b1;
            r_state     <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (r_cnt == '0) begin
            r_state        <= S_EXPOSE;
            r_mod_en       <= 1'b1;
            r_cnt          <= CNT_W'(r_exp_load);
            r_frame_strobe <= (r_exp_load == '0);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        S_EXPOSE: begin
          if (r_cnt == '0) begin
            r_mod_en <= 1'b0;
            if (r_phase_idx == r_last_idx) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_phase_idx <= r_phase_idx + 5'd1;
              r_phase_sel <= r_phase_sel + r_step;
              r_cnt       <= SETTLE_LOAD;
              r_state     <= S_SETTLE;
            end
          end else begin
            // Strobe lands on the cycle whose counter value will be zero.
            r_cnt          <= r_cnt - CNT_W'(1);
            r_frame_strobe <= (r_cnt == CNT_W'(1));
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_mod_en <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign W_FREQ_SEL   = r_freq_sel;
  assign W_PHASE_SEL  = r_phase_sel;
  assign W_DUTY_SEL   = r_duty_sel;
  assign MOD_EN       = r_mod_en;
  assign PHASE_IDX    = r_phase_idx;
  assign FRAME_STROBE = r_frame_strobe;
  assign BUSY         = r_busy;
  assign DONE         = r_done;

endmodule

// File: tb/tb_mod_phase_sequencer.sv
// Directed testbench for mod_phase_sequencer with SETTLE_CYCLES=4.
module tb_mod_phase_sequencer;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        RESET_N, START, ABORT;
  logic [2:0]  CFG_FREQ_SEL;
  logic [3:0]  CFG_DUTY_SEL;
  logic [4:0]  CFG_PHASE_START, CFG_PHASE_STEP, CFG_NUM_PHASES;
  logic [15:0] CFG_EXPOSURE;
  logic [2:0]  W_FREQ_SEL;
  logic [4:0]  W_PHASE_SEL;
  logic [3:0]  W_DUTY_SEL;
  logic        MOD_EN;
  logic [4:0]  PHASE_IDX;
  logic        FRAME_STROBE, BUSY, DONE;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mod_phase_sequencer #(.SETTLE_CYCLES(S), .EXP_W(16)) dut (
    .USER_CLOCK(clk), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
    .CFG_FREQ_SEL(CFG_FREQ_SEL), .CFG_DUTY_SEL(CFG_DUTY_SEL),
    .CFG_PHASE_START(CFG_PHASE_START), .CFG_PHASE_STEP(CFG_PHASE_STEP),
    .CFG_NUM_PHASES(CFG_NUM_PHASES), .CFG_EXPOSURE(CFG_EXPOSURE),
    .W_FREQ_SEL(W_FREQ_SEL), .W_PHASE_SEL(W_PHASE_SEL), .W_DUTY_SEL(W_DUTY_SEL),
    .MOD_EN(MOD_EN), .PHASE_IDX(PHASE_IDX), .FRAME_STROBE(FRAME_STROBE),
    .BUSY(BUSY), .DONE(DONE)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [2:0] f, input logic [3:0] d, input logic [4:0] ps,
                         input logic [4:0] st, input logic [4:0] n, input logic [15:0] e);
    CFG_FREQ_SEL    = f;
    CFG_DUTY_SEL    = d;
    CFG_PHASE_START = ps;
    CFG_PHASE_STEP  = st;
    CFG_NUM_PHASES  = n;
    CFG_EXPOSURE    = e;
  endtask

  // Returns at the sample point just after the edge that accepted START (j=0).
  task automatic pulse_start;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic test_reset;
    logic [22:0] obs;
    RESET_N = 1'b0;
    START   = 1'b1;
    ABORT   = 1'b1;
    tick();
    tick();
    START = 1'b0;
    ABORT = 1'b0;
    obs = {W_FREQ_SEL, W_PHASE_SEL, W_DUTY_SEL, PHASE_IDX, MOD_EN, FRAME_STROBE, BUSY, DONE};
    tests++;
    if (obs !== 23'd0) begin
      fails++;
      $display("FAIL reset_outputs got %h expected 000000", obs);
    end
    RESET_N = 1'b1;
    tick();
    tests++;
    if ({BUSY, MOD_EN, DONE} !== 3'b000) begin
      fails++;
      $display("FAIL reset_idle got busy/mod/done=%b expected 000", {BUSY, MOD_EN, DONE});
    end
    $display("[TB] reset: outputs cleared");
  endtask

  task automatic test_basic_sweep;
    int strobes;
    int p, off;
    logic [3:0] exp_flags;
    strobes = 0;
    set_cfg(3'd3, 4'd8, 5'd2, 5'd8, 5'd4, 16'd10);
    pulse_start();
    for (int j = 0; j < 56; j++) begin
      if (j > 0) tick();
      p   = j / 14;
      off = j % 14;
      exp_flags = {(off >= S), (off == 13), 1'b1, 1'b0};
      tests++;
      if ({MOD_EN, FRAME_STROBE, BUSY, DONE} !== exp_flags) begin
        fails++;
        $display("FAIL basic_flags j=%0d got mod/strb/busy/done=%b expected %b", j,
                 {MOD_EN, FRAME_STROBE, BUSY, DONE}, exp_flags);
      end
      tests++;
      if (W_PHASE_SEL !== 5'(2 + 8 * p) || PHASE_IDX !== 5'(p) ||
          W_FREQ_SEL !== 3'd3 || W_DUTY_SEL !== 4'd8) begin
        fails++;
        $display("FAIL basic_sel j=%0d got phase=%0d idx=%0d freq=%0d duty=%0d expected %0d %0d 3 8",
                 j, W_PHASE_SEL, PHASE_IDX, W_FREQ_SEL, W_DUTY_SEL, 2 + 8 * p, p);
      end
      if (FRAME_STROBE === 1'b1) strobes++;
    end
    tick();
    tests++;
    if ({DONE, BUSY, MOD_EN} !== 3'b100 || W_PHASE_SEL !== 5'd26) begin
      fails++;
      $display("FAIL basic_done got done/busy/mod=%b phase=%0d expected 100 26",
               {DONE, BUSY, MOD_EN}, W_PHASE_SEL);
    end
    tick();
    tests++;
    if (DONE !== 1'b0) begin
      fails++;
      $display("FAIL basic_done_pulse got done=%b expected 0", DONE);
    end
    tests++;
    if (strobes != 4) begin
      fails++;
      $display("FAIL basic_strobes got %0d expected 4", strobes);
    end
    $display("[TB] basic sweep: 4 phases, %0d strobes", strobes);
  endtask

  task automatic test_wrap;
    logic [4:0] exp_ph [3];
    exp_ph = '{5'd30, 5'd3, 5'd8};
    set_cfg(3'd1, 4'd2, 5'd30, 5'd5, 5'd3, 16'd2);
    pulse_start();
    for (int j = 0; j < 18; j++) begin
      if (j > 0) tick();
      if (j % 6 == 0) begin
        tests++;
        if (W_PHASE_SEL !== exp_ph[j / 6] || PHASE_IDX !== 5'(j / 6)) begin
          fails++;
          $display("FAIL wrap_phase j=%0d got phase=%0d idx=%0d expected %0d %0d",
                   j, W_PHASE_SEL, PHASE_IDX, exp_ph[j / 6], j / 6);
        end
      end
      tests++;
      if (BUSY !== 1'b1 || DONE !== 1'b0) begin
        fails++;
        $display("FAIL wrap_busy j=%0d got busy/done=%b expected 10", j, {BUSY, DONE});
      end
    end
    tick();
    tests++;
    if ({DONE, BUSY} !== 2'b10) begin
      fails++;
      $display("FAIL wrap_done got done/busy=%b expected 10", {DONE, BUSY});
    end
    $display("[TB] wrap sweep: phases 30,3,8");
  endtask

  task automatic test_clamp;
    int mod_cycles;
    logic [3:0] exp_flags;
    mod_cycles = 0;
    set_cfg(3'd7, 4'd3, 5'd7, 5'd1, 5'd0, 16'd0);
    pulse_start();
    tests++;
    if (W_FREQ_SEL !== 3'd5 || W_DUTY_SEL !== 4'd3 || W_PHASE_SEL !== 5'd7) begin
      fails++;
      $display("FAIL clamp_sel got freq=%0d duty=%0d phase=%0d expected 5 3 7",
               W_FREQ_SEL, W_DUTY_SEL, W_PHASE_SEL);
    end
    for (int j = 0; j <= 6; j++) begin
      if (j > 0) tick();
      exp_flags = {(j == 4), (j == 4), (j < 5), (j == 5)};
      tests++;
      if ({MOD_EN, FRAME_STROBE, BUSY, DONE} !== exp_flags) begin
        fails++;
        $display("FAIL clamp_flags j=%0d got mod/strb/busy/done=%b expected %b", j,
                 {MOD_EN, FRAME_STROBE, BUSY, DONE}, exp_flags);
      end
      if (MOD_EN === 1'b1) mod_cycles++;
    end
    tests++;
    if (mod_cycles != 1) begin
      fails++;
      $display("FAIL clamp_mod_cycles got %0d expected 1", mod_cycles);
    end
    $display("[TB] clamp: freq 7->5, one phase, %0d exposure cycle(s)", mod_cycles);
  endtask

  task automatic test_abort;
    int mod_cycles, done_at;
    logic saw_bad;
    set_cfg(3'd3, 4'd8, 5'd2, 5'd8, 5'd4, 16'd10);
    pulse_start();
    for (int j = 1; j <= 20; j++) tick();
    tests++;
    if (MOD_EN !== 1'b1 || PHASE_IDX !== 5'd1) begin
      fails++;
      $display("FAIL abort_pre got mod=%b idx=%0d expected 1 1", MOD_EN, PHASE_IDX);
    end
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    tests++;
    if ({BUSY, MOD_EN, FRAME_STROBE, DONE} !== 4'b0000 ||
        W_PHASE_SEL !== 5'd10 || W_FREQ_SEL !== 3'd3 || W_DUTY_SEL !== 4'd8) begin
      fails++;
      $display("FAIL abort_state got busy/mod/strb/done=%b phase=%0d freq=%0d duty=%0d expected 0000 10 3 8",
               {BUSY, MOD_EN, FRAME_STROBE, DONE}, W_PHASE_SEL, W_FREQ_SEL, W_DUTY_SEL);
    end
    saw_bad = 1'b0;
    for (int j = 0; j < 60; j++) begin
      tick();
      if (DONE !== 1'b0 || BUSY !== 1'b0 || MOD_EN !== 1'b0) saw_bad = 1'b1;
    end
    tests++;
    if (saw_bad !== 1'b0) begin
      fails++;
      $display("FAIL abort_quiet got activity=%b expected 0", saw_bad);
    end
    mod_cycles = 0;
    done_at    = -1;
    pulse_start();
    for (int j = 0; j <= 57; j++) begin
      if (j > 0) tick();
      if (MOD_EN === 1'b1) mod_cycles++;
      if (DONE === 1'b1 && done_at < 0) done_at = j;
    end
    tests++;
    if (mod_cycles != 40 || done_at != 56) begin
      fails++;
      $display("FAIL abort_rerun got mod_cycles=%0d done_at=%0d expected 40 56", mod_cycles, done_at);
    end
    $display("[TB] abort: sweep abandoned, rerun done_at=%0d", done_at);
  endtask

  task automatic test_start_abort_same;
    set_cfg(3'd4, 4'd1, 5'd9, 5'd2, 5'd2, 16'd3);
    START = 1'b1;
    ABORT = 1'b1;
    tick();
    START = 1'b0;
    ABORT = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) tick();
      tests++;
      if (BUSY !== 1'b0 || W_FREQ_SEL !== 3'd3 || W_PHASE_SEL !== 5'd26) begin
        fails++;
        $display("FAIL start_abort j=%0d got busy=%b freq=%0d phase=%0d expected 0 3 26",
                 j, BUSY, W_FREQ_SEL, W_PHASE_SEL);
      end
    end
    $display("[TB] start+abort: no sweep started");
  endtask

  task automatic test_busy_ignore;
    logic [4:0] exp_phase;
    set_cfg(3'd2, 4'd5, 5'd4, 5'd3, 5'd2, 16'd3);
    pulse_start();
    for (int j = 0; j <= 15; j++) begin
      if (j > 0) tick();
      if (j == 2) begin
        START = 1'b1;
        set_cfg(3'd6, 4'd15, 5'd20, 5'd11, 5'd9, 16'd50);
      end
      if (j == 3) START = 1'b0;
      exp_phase = (j < 7) ? 5'd4 : 5'd7;
      tests++;
      if (W_FREQ_SEL !== 3'd2 || W_DUTY_SEL !== 4'd5 || W_PHASE_SEL !== exp_phase ||
          BUSY !== (j < 14) || DONE !== (j == 14)) begin
        fails++;
        $display("FAIL busy_ignore j=%0d got freq=%0d duty=%0d phase=%0d busy=%b done=%b expected 2 5 %0d %b %b",
                 j, W_FREQ_SEL, W_DUTY_SEL, W_PHASE_SEL, BUSY, DONE, exp_phase, (j < 14), (j == 14));
      end
    end
    $display("[TB] busy: START and CFG changes ignored mid-sweep");
  endtask

  task automatic test_reset_mid;
    logic [22:0] obs;
    logic saw_bad;
    set_cfg(3'd3, 4'd8, 5'd2, 5'd8, 5'd4, 16'd10);
    pulse_start();
    tick();
    tick();
    RESET_N = 1'b0;
    tick();
    obs = {W_FREQ_SEL, W_PHASE_SEL, W_DUTY_SEL, PHASE_IDX, MOD_EN, FRAME_STROBE, BUSY, DONE};
    tests++;
    if (obs !== 23'd0) begin
      fails++;
      $display("FAIL reset_mid got %h expected 000000", obs);
    end
    RESET_N = 1'b1;
    saw_bad = 1'b0;
    for (int j = 0; j < 60; j++) begin
      tick();
      if (DONE !== 1'b0 || BUSY !== 1'b0) saw_bad = 1'b1;
    end
    tests++;
    if (saw_bad !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_quiet got activity=%b expected 0", saw_bad);
    end
    $display("[TB] reset mid-sweep: sweep abandoned");
  endtask

  initial begin
    RESET_N = 1'b0;
    START   = 1'b0;
    ABORT   = 1'b0;
    set_cfg(3'd0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0);
    #1;
    test_reset();
    test_basic_sweep();
    test_wrap();
    test_clamp();
    test_abort();
    test_start_abort_same();
    test_busy_ignore();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
